mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Parametrised, clocked successor to the 16-byte edge-strobed memory model: a single-port RAM behind a valid/ready request channel and a valid/ready response channel, with configurable wait states to mimic slow memory. It sits between a CPU-side master and storage. It adds three things to the flat memory: byte-enable writes, out-of-range error reporting, and held responses under back-pressure.

## Interface
Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
- WAIT_CYC, 0: extra wait cycles per access, 0..255.

Ports:
- clk  in  1  single clock; all logic samples on the rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  address ≥ DEPTH.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - BUSY: counts wait cycles, then performs the access.
  - RESP: rsp_valid=1.
- Handshake: a request is accepted on an edge where req_valid && req_ready.
  - req_write, req_addr, req_wdata and req_be are captured into internal registers at that edge.
  - Inputs are don't-care afterwards.
- IDLE → BUSY on accept; the wait counter loads WAIT_CYC.
- BUSY:
  - If the counter ≠ 0, decrement it.
  - If the counter = 0, perform the access at this edge and go to RESP.
- Access rules:
  - Write: each byte i with be[i]=1 is updated; bytes with be[i]=0 are unchanged.
  - Read: rsp_rdata ← mem[addr].
  - Address ≥ DEPTH: no storage change, rsp_err=1, rsp_rdata=0.
  - be all-zero write: legal, no change, normal response.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready. Go to IDLE at that edge.
- No request is accepted while busy; there is exactly one outstanding transaction.
- Storage contents are not reset. Reads of never-written words return X in simulation; the bench must not check them.

## Timing
- Reset values: req_ready=0 while reset is asserted, then 1 (IDLE) once released. rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Accept at edge N → access at edge N+WAIT_CYC+1 → rsp_valid high in the cycle after that edge.
- With rsp_ready held at 1:
  - the response handshake occurs at edge N+WAIT_CYC+2;
  - req_ready returns to 1 after that edge;
  - peak throughput is one transaction per WAIT_CYC+3 cycles.
- Back-pressure: rsp_ready=0 holds RESP indefinitely, with no change to any output.
- Read-after-write to the same address returns the new data; the write completes before the read can be accepted.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight transaction is dropped with no response.
  - A write whose access edge has not occurred leaves storage unchanged.
  - A write already performed remains in storage.
- rsp_ready asserted while not in RESP has no effect.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the wait-counter width constant (8);
  - a function computing the byte-lane count DATA_W/8.
- Sub-module mem_array holds the storage:
  - DEPTH×DATA_W, with a clocked byte-enable write and a clocked read;
  - its write and read strobes are driven by mem_ctrl in BUSY.
- mem_ctrl holds the FSM, the wait counter, the request capture registers, the range check and the response registers.

## Test plan
- Write then read, defaults: write addr 3, data 0xA5, be=1, then read addr 3 → rsp_rdata=0xA5, rsp_err=0, response 1 cycle after accept.
- Byte enables, DATA_W=32: write 0x11223344 be=1111, then 0xAABBCCDD be=0101 at addr 2 → read returns 0x11BB33DD.
- Wait states, WAIT_CYC=3: accept at edge N → rsp_valid first high after edge N+4; req_ready=0 and busy=1 throughout.
- Out of range, DEPTH=10, ADDR_W=4:
  - write addr 12 → rsp_err=1 and addr 12 mod 10 (addr 2) is unchanged;
  - read addr 15 → rsp_err=1, rsp_rdata=0.
- Back-pressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0; release → IDLE on the next edge.
- Reset mid-write, WAIT_CYC=2: assert reset one cycle after accepting a write of 0x5A to addr 7 (previously 0x00) → outputs at reset values immediately, no response, and a later read of addr 7 returns 0x00.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the mem_ctrl memory controller.
//   state_e    - controller FSM states (IDLE, BUSY, RESP)
//   WAIT_W     - width of the wait-state counter
//   byte_lanes - number of 8-bit lanes in a data word
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WAIT_W = 8;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W single-port storage with a clocked byte-enable
// write and a clocked (registered) read. Contents are not reset.
//   clk      - clock
//   wr_en_i  - write strobe; bytes with be_i[i]=1 are written at the edge
//   rd_en_i  - read strobe; rdata_o loads mem[addr_i] at the edge
//   addr_i   - word address (only used while a strobe is high)
//   wdata_i  - write data
//   be_i     - byte enables
//   rdata_o  - registered read data, held until the next read strobe
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [DATA_W/8-1:0]    be_i,
    output logic [DATA_W-1:0]      rdata_o
);

    localparam int LANES = byte_lanes(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM behind a request channel and a response channel,
// with WAIT_CYC extra wait states per access, byte-enable writes and
// out-of-range error reporting.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The request side is accepted only in IDLE; the response side holds
// rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready is seen.
//
//   clk       - clock
//   reset     - asynchronous active-high reset of all control state
//   req_valid - request present
//   req_ready - controller can accept a request (IDLE, not in reset)
//   req_write - 1 = write, 0 = read
//   req_addr  - word address
//   req_wdata - write data
//   req_be    - byte enables for writes
//   rsp_valid - response present
//   rsp_ready - master accepts the response
//   rsp_rdata - read data; 0 for writes and errors
//   rsp_err   - address was >= DEPTH
//   busy      - FSM is not in IDLE
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int            LANES   = byte_lanes(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]    be_q,    be_d;
    logic                err_q,   err_d;
    // Response carries array read data (in-range read) rather than zero.
    logic                rdsel_q, rdsel_d;

    logic                in_range;
    logic                access;
    logic                arr_we;
    logic                arr_re;
    logic [DATA_W-1:0]   arr_rdata;

    // Zero-extend so DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign access   = (state_q == BUSY) && (wait_q == '0);
    assign arr_we   = access && write_q && in_range;
    assign arr_re   = access && !write_q && in_range;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdsel_d = rdsel_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    wait_d  = WAIT_W'(WAIT_CYC);
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                end
            end
            BUSY: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    state_d = RESP;
                    err_d   = !in_range;
                    rdsel_d = !write_q && in_range;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdsel_q <= rdsel_d;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en_i (arr_we),
        .rd_en_i (arr_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (arr_rdata)
    );

    // req_ready is masked by reset because the async clear already shows IDLE.
    assign req_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && rdsel_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 10;
  localparam int WAIT_CYC = 2;
  localparam int LANES    = DATA_W / 8;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  mem_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: one outstanding request, its age in edges since
  // acceptance, the storage performed WAIT_CYC+1 edges after acceptance, and
  // a response visible from then until a handshake edge.
  logic [DATA_W-1:0] m_mem   [DEPTH];
  logic [LANES-1:0]  m_known [DEPTH];
  bit                m_busy;
  int                m_age;
  bit                m_wr;
  int                m_addr;
  logic [DATA_W-1:0] m_wd;
  logic [LANES-1:0]  m_be;
  logic [DATA_W-1:0] m_data;
  bit                m_err;
  bit                m_data_known;

  initial begin
    m_busy = 0;
    m_age  = 0;
    m_err  = 0;
    m_data = '0;
    m_data_known = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = '0;
  end

  task automatic model_access();
    if (m_addr >= DEPTH) begin
      m_err = 1; m_data = '0; m_data_known = 1;
    end else if (m_wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (m_be[l]) begin
          m_mem[m_addr][l*8 +: 8] = m_wd[l*8 +: 8];
          m_known[m_addr][l] = 1'b1;
        end
      end
      m_err = 0; m_data = '0; m_data_known = 1;
    end else begin
      m_err = 0;
      m_data = m_mem[m_addr];
      m_data_known = &m_known[m_addr];
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (m_age == WAIT_CYC) model_access();
      if (m_age >= WAIT_CYC + 1 && rsp_ready) m_busy = 0;
      else m_age++;
    end else if (req_valid) begin
      m_busy = 1;
      m_age  = 0;
      m_wr   = req_write;
      m_addr = int'(req_addr);
      m_wd   = req_wdata;
      m_be   = req_be;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit exp_valid;
    if (reset) begin
      check("rst_req_ready", DATA_W'(req_ready), '0);
      check("rst_busy",      DATA_W'(busy),      '0);
      check("rst_rsp_valid", DATA_W'(rsp_valid), '0);
      check("rst_rsp_err",   DATA_W'(rsp_err),   '0);
      check("rst_rsp_rdata", rsp_rdata,          '0);
    end else begin
      exp_valid = m_busy && (m_age >= WAIT_CYC + 1);
      check("req_ready", DATA_W'(req_ready), DATA_W'(!m_busy));
      check("busy",      DATA_W'(busy),      DATA_W'(m_busy));
      check("rsp_valid", DATA_W'(rsp_valid), DATA_W'(exp_valid));
      if (exp_valid) begin
        check("rsp_err", DATA_W'(rsp_err), DATA_W'(m_err));
        if (m_data_known) check("rsp_rdata", rsp_rdata, m_data);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input bit wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wd, input logic [LANES-1:0] be,
                     input int hold, output logic [DATA_W-1:0] rd,
                     output logic err, output int lat);
    int n;
    rd = 'x; err = 1'bx; lat = -1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_wait", DATA_W'(req_ready), DATA_W'(1));
    if (!req_ready) return;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    // Request fields are don't-care after acceptance: scramble them.
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = ADDR_W'($urandom_range(0, 15));
    req_wdata = $urandom;
    req_be    = LANES'($urandom_range(0, 15));
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      if (hold == 0) rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    check("rsp_wait", DATA_W'(rsp_valid), DATA_W'(1));
    if (!rsp_valid) return;
    rd  = rsp_rdata;
    err = rsp_err;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      check("hold_valid",  DATA_W'(rsp_valid), DATA_W'(1));
      check("hold_rdata",  rsp_rdata, rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] rd;
    logic              err;
    int                lat;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // write then read, with latency measured in edges from accept to response
    txn(1'b1, 4'd3, 32'h0000_00A5, 4'hF, 0, rd, err, lat);
    check("wr3_err", DATA_W'(err), '0);
    check("wr3_rdata", rd, '0);
    txn(1'b0, 4'd3, '0, '0, 0, rd, err, lat);
    check("rd3_rdata", rd, 32'h0000_00A5);
    check("rd3_err", DATA_W'(err), '0);
    check("rd3_latency", DATA_W'(lat), 32'd3);
    check("idle_after_rsp", DATA_W'(req_ready), DATA_W'(1));

    // byte enables
    txn(1'b1, 4'd2, 32'h1122_3344, 4'b1111, 0, rd, err, lat);
    txn(1'b1, 4'd2, 32'hAABB_CCDD, 4'b0101, 0, rd, err, lat);
    txn(1'b0, 4'd2, '0, '0, 0, rd, err, lat);
    check("be_merge", rd, 32'h11BB_33DD);

    // all-zero byte enables: normal response, no change
    txn(1'b1, 4'd2, 32'hFFFF_FFFF, 4'b0000, 0, rd, err, lat);
    check("be0_err", DATA_W'(err), '0);
    txn(1'b0, 4'd2, '0, '0, 0, rd, err, lat);
    check("be0_keep", rd, 32'h11BB_33DD);

    // out of range
    txn(1'b1, 4'd12, 32'hDEAD_BEEF, 4'hF, 0, rd, err, lat);
    check("oob_wr_err", DATA_W'(err), DATA_W'(1));
    check("oob_wr_rdata", rd, '0);
    txn(1'b0, 4'd2, '0, '0, 0, rd, err, lat);
    check("oob_alias_keep", rd, 32'h11BB_33DD);
    txn(1'b0, 4'd15, '0, '0, 0, rd, err, lat);
    check("oob_rd_err", DATA_W'(err), DATA_W'(1));
    check("oob_rd_rdata", rd, '0);

    // back-pressure for 5 cycles
    txn(1'b0, 4'd2, '0, '0, 5, rd, err, lat);
    check("bp_rdata", rd, 32'h11BB_33DD);
    check("bp_idle_after", DATA_W'(req_ready), DATA_W'(1));

    // reset in the middle of a write before its access edge
    txn(1'b1, 4'd7, 32'h0000_0000, 4'hF, 0, rd, err, lat);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd7;
    req_wdata = 32'h0000_005A;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy", DATA_W'(busy), DATA_W'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy",      DATA_W'(busy),      '0);
    check("mid_rst_req_ready", DATA_W'(req_ready), '0);
    check("mid_rst_rsp_valid", DATA_W'(rsp_valid), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    txn(1'b0, 4'd7, '0, '0, 0, rd, err, lat);
    check("mid_rst_keep", rd, 32'h0000_0000);

    // randomized traffic
    repeat (150) begin
      int hold;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      txn(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom,
          LANES'($urandom_range(0, 15)), hold, rd, err, lat);
      check("rnd_latency", DATA_W'(lat), DATA_W'(WAIT_CYC + 1));
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
